// File: rtl/window_pkg.sv
// Shared constants for the 3x3 sliding-window block.
// Window geometry and sum-width growth used by window_3x3 and its row shifter.
package window_pkg;

  localparam int WIN_SIZE   = 3;
  localparam int SUM_GROWTH = 4;

  // Flat bit offset of element (r,c) inside a packed window of w-bit elements.
  function automatic int unsigned win_lsb(input int unsigned r, input int unsigned c,
                                          input int unsigned w);
    return (r * WIN_SIZE + c) * w;
  endfunction

endpackage

// File: rtl/window_3x3_win_row_shift.sv
// win_row_shift: one row of the window, a WIN_SIZE-tap enabled shift register.
// Latency: newest tap updates 1 cycle after en. Backpressure: none, shifts on every en.
module win_row_shift
  import window_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [DATA_WIDTH-1:0]          din,
  output logic [WIN_SIZE*DATA_WIDTH-1:0] taps
);

  // Tap 0 (lowest slice) is the oldest column, the top slice the newest.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taps <= '0;
    end else if (en) begin
      taps <= {din, taps[WIN_SIZE*DATA_WIDTH-1:DATA_WIDTH]};
    end
  end

endmodule

// File: rtl/window_3x3.sv
// window_3x3: 3x3 sliding window over three column-aligned lines; win_sum via WINDOW_3X3_WIN_SUM_EN.
// Latency: 1 cycle from accepted column to win_data/out_valid. Backpressure: none, accepts every in_valid.
module window_3x3
  import window_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LENGTH     = 100,
  parameter int CNT_WIDTH  = 7
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DATA_WIDTH-1:0]           in_row_0,
  input  logic [DATA_WIDTH-1:0]           in_row_1,
  input  logic [DATA_WIDTH-1:0]           in_row_2,
  input  logic                            in_valid,
  output logic [9*DATA_WIDTH-1:0]         win_data,
`ifdef WINDOW_3X3_WIN_SUM_EN
  output logic [DATA_WIDTH+SUM_GROWTH-1:0] win_sum,
`endif
  output logic                            out_valid,
  output logic                            out_last
);

  localparam int ROW_W = WIN_SIZE * DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_COL  = CNT_WIDTH'(LENGTH - 1);
  localparam logic [CNT_WIDTH-1:0] FIRST_WIN = CNT_WIDTH'(WIN_SIZE - 1);

  logic [DATA_WIDTH-1:0] row_in [WIN_SIZE];
  logic [CNT_WIDTH-1:0]  col_cnt;
  logic                  col_wrap;

  assign row_in[0] = in_row_0;
  assign row_in[1] = in_row_1;
  assign row_in[2] = in_row_2;

  assign col_wrap = (col_cnt == LAST_COL);

  for (genvar r = 0; r < WIN_SIZE; r++) begin : g_row
    win_row_shift #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_row (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (in_valid),
      .din   (row_in[r]),
      .taps  (win_data[r*ROW_W +: ROW_W])
    );
  end

  // A window is only complete from the third column of a line onward, so
  // windows never mix the tail of one line with the head of the next.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_cnt   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= in_valid && (col_cnt >= FIRST_WIN);
      out_last  <= in_valid && col_wrap;
      if (in_valid) begin
        col_cnt <= col_wrap ? '0 : col_cnt + 1'b1;
      end
    end
  end

`ifdef WINDOW_3X3_WIN_SUM_EN
  localparam int SUM_W = DATA_WIDTH + SUM_GROWTH;

  logic [SUM_W-1:0] row_sum [WIN_SIZE];
  logic [SUM_W-1:0] sum_nxt;

  // Sum the window as it will look after this shift, so the registered sum
  // lines up with win_data on the same cycle.
  always_comb begin
    sum_nxt = '0;
    for (int r = 0; r < WIN_SIZE; r++) begin
      row_sum[r] = SUM_W'(row_in[r])
                 + SUM_W'(win_data[win_lsb(r, 2, DATA_WIDTH) +: DATA_WIDTH])
                 + SUM_W'(win_data[win_lsb(r, 1, DATA_WIDTH) +: DATA_WIDTH]);
      sum_nxt    = sum_nxt + row_sum[r];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_sum <= '0;
    end else if (in_valid) begin
      win_sum <= sum_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_window_3x3.sv
// Directed bench for window_3x3 (LENGTH=8) with a scoreboard of expected windows.
module tb_window_3x3;

  localparam int DW  = 16;
  localparam int LEN = 8;
  localparam int CW  = 3;
  localparam int WW  = 9 * DW;
  localparam int SW  = DW + 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_row_0, in_row_1, in_row_2;
  logic          in_valid;
  logic [WW-1:0] win_data;
  logic          out_valid, out_last;
`ifdef WINDOW_3X3_WIN_SUM_EN
  logic [SW-1:0] win_sum;
`endif

  typedef struct {
    logic [WW-1:0] dat;
    logic          last;
    logic [SW-1:0] sum;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mw [3][3];
  int            mcol     = 0;
  int            checks   = 0;
  int            errors   = 0;
  int            vld_cnt  = 0;
  int            last_cnt = 0;

  window_3x3 #(
    .DATA_WIDTH (DW),
    .LENGTH     (LEN),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_row_0  (in_row_0),
    .in_row_1  (in_row_1),
    .in_row_2  (in_row_2),
    .in_valid  (in_valid),
    .win_data  (win_data),
`ifdef WINDOW_3X3_WIN_SUM_EN
    .win_sum   (win_sum),
`endif
    .out_valid (out_valid),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] pack_model();
    logic [WW-1:0] p;
    p = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        p[(r*3+c)*DW +: DW] = mw[r][c];
    return p;
  endfunction

  function automatic logic [SW-1:0] model_sum();
    logic [SW-1:0] s;
    s = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        s = s + SW'(mw[r][c]);
    return s;
  endfunction

  // Drive one cycle, advance the model at the edge, check outputs at the falling edge.
  task automatic step(input logic rst, input logic v,
                      input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
    logic exp_vld;
    exp_t e;
    rst_n    = rst;
    in_valid = v;
    in_row_0 = a;
    in_row_1 = b;
    in_row_2 = c;
    @(posedge clk);
    exp_vld = 1'b0;
    if (!rst) begin
      for (int r = 0; r < 3; r++)
        for (int k = 0; k < 3; k++)
          mw[r][k] = '0;
      mcol = 0;
      sb.delete();
    end else if (v) begin
      for (int r = 0; r < 3; r++) begin
        mw[r][0] = mw[r][1];
        mw[r][1] = mw[r][2];
      end
      mw[0][2] = a;
      mw[1][2] = b;
      mw[2][2] = c;
      if (mcol >= 2) begin
        exp_vld = 1'b1;
        e.dat  = pack_model();
        e.last = (mcol == LEN - 1);
        e.sum  = model_sum();
        sb.push_back(e);
      end
      mcol = (mcol == LEN - 1) ? 0 : mcol + 1;
    end
    @(negedge clk);
    chk("out_valid", WW'(out_valid), WW'(exp_vld));
    chk("win_data", win_data, pack_model());
    if (out_valid) begin
      vld_cnt++;
      if (out_last) last_cnt++;
      chk("sb_nonempty", WW'(sb.size() != 0), WW'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_data", win_data, e.dat);
        chk("sb_last", WW'(out_last), WW'(e.last));
`ifdef WINDOW_3X3_WIN_SUM_EN
        chk("sb_sum", WW'(win_sum), WW'(e.sum));
`endif
      end
    end else begin
      chk("out_last_idle", WW'(out_last), WW'(0));
    end
  endtask

  initial begin
    int v0;
    rst_n = 1'b0; in_valid = 1'b0;
    in_row_0 = '0; in_row_1 = '0; in_row_2 = '0;
    @(negedge clk);

    // Reset held for 3 cycles with in_valid high: outputs stay 0.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, DW'($urandom), DW'($urandom), DW'($urandom));
      chk("rst_out_valid", WW'(out_valid), WW'(0));
      chk("rst_win_data", win_data, WW'(0));
`ifdef WINDOW_3X3_WIN_SUM_EN
      chk("rst_win_sum", WW'(win_sum), WW'(0));
`endif
    end

    // One line with a 3-cycle gap after column 3.
    vld_cnt = 0; last_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 1'b1, DW'(c), DW'(16 + c), DW'(32 + c));
      if (c == 2) begin
        chk("first_row0", WW'(win_data[0 +: 3*DW]), WW'(48'h0002_0001_0000));
        chk("first_row2", WW'(win_data[6*DW +: 3*DW]), WW'(48'h0022_0021_0020));
      end
    end
    for (int g = 0; g < 3; g++)
      step(1'b1, 1'b0, DW'($urandom), DW'($urandom), DW'($urandom));
    for (int c = 4; c < 8; c++) begin
      step(1'b1, 1'b1, DW'(c), DW'(16 + c), DW'(32 + c));
      if (c == 4) chk("gap_row0", WW'(win_data[0 +: 3*DW]), WW'(48'h0004_0003_0002));
      if (c == 7) chk("line1_last", WW'(out_last), WW'(1));
    end
    chk("line1_pulses", WW'(vld_cnt), WW'(6));
    chk("line1_lasts", WW'(last_cnt), WW'(1));

    // Two back-to-back lines.
    vld_cnt = 0; last_cnt = 0;
    for (int i = 0; i < 2 * LEN; i++) begin
      step(1'b1, 1'b1, DW'(100 + i), DW'(200 + i), DW'(300 + i));
      if (i == LEN || i == LEN + 1) chk("line2_head_novld", WW'(out_valid), WW'(0));
    end
    chk("two_line_pulses", WW'(vld_cnt), WW'(12));
    chk("two_line_lasts", WW'(last_cnt), WW'(2));

    // Saturated pixels: largest possible window sum.
    for (int c = 0; c < LEN; c++)
      step(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF);
`ifdef WINDOW_3X3_WIN_SUM_EN
    chk("sum_max", WW'(win_sum), WW'(20'h8FFF7));
`endif

    // Reset at column 5 discards the partial line.
    for (int c = 0; c < 6; c++)
      step(1'b1, 1'b1, DW'($urandom), DW'($urandom), DW'($urandom));
    step(1'b0, 1'b1, DW'($urandom), DW'($urandom), DW'($urandom));
    chk("midrst_out_valid", WW'(out_valid), WW'(0));
    v0 = vld_cnt;
    step(1'b1, 1'b1, 16'h0A, 16'h1A, 16'h2A);
    step(1'b1, 1'b1, 16'h0B, 16'h1B, 16'h2B);
    chk("restart_two_cols_novld", WW'(vld_cnt - v0), WW'(0));
    step(1'b1, 1'b1, 16'h0C, 16'h1C, 16'h2C);
    chk("restart_third_col_vld", WW'(vld_cnt - v0), WW'(1));
    chk("restart_row1", WW'(win_data[3*DW +: 3*DW]), WW'(48'h001C_001B_001A));
    step(1'b1, 1'b0, '0, '0, '0);

    chk("sb_drained", WW'(sb.size()), WW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
